dram_port_ctrl: RTL and testbench

DRAM_PORT_CTRL -- requirements
Module: dram_port_ctrl

---
 rtl/dram_port_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dram_port_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_ctrl.sv
// ---------------------------------------------------------------------------
// dram_port_ctrl
//
// Purpose:
//   Turns a command stream into single-port memory accesses. A write is a
//   single beat that goes straight to the memory in the cycle it is accepted.
//   A read is a burst of 1..16 beats at consecutive addresses. The returned
//   data is queued in a small response FIFO. A beat is issued only when a
//   FIFO slot is guaranteed for it, so the FIFO cannot overflow.
//
// Ports:
//   clk, reset              - single clock; synchronous active-high reset
//   cmd_valid / cmd_ready   - command handshake
//   cmd_we                  - 1 = write beat, 0 = read burst
//   cmd_addr                - start address
//   cmd_len                 - read beats minus one
//   cmd_wdata               - write data
//   rsp_valid / rsp_ready   - read-response handshake
//   rsp_rdata               - head of the response FIFO
//   busy                    - burst active, read in flight, or data queued
//   mem_ena/rea/wea         - memory port enables
//   mem_addra               - memory address
//   mem_dia                 - memory write data
//   mem_doa                 - memory read data (one cycle after a read)
//   dbg_state               - current FSM state (0 = IDLE, 1 = RD_BURST)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. A producer holding valid keeps its payload stable until the
// transfer, and valid never depends on ready.
// ---------------------------------------------------------------------------
module dram_port_ctrl #(
    parameter int AW        = 11,
    parameter int DW        = 64,
    parameter int RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [3:0]    cmd_len,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          busy,
    output logic          mem_ena,
    output logic          mem_rea,
    output logic          mem_wea,
    output logic [AW-1:0] mem_addra,
    output logic [DW-1:0] mem_dia,
    input  logic [DW-1:0] mem_doa,
    output logic          dbg_state
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE     = 1'b0,
        RD_BURST = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [3:0]    remaining_q, remaining_d;
    logic          rd_pending_q;
    logic [DW-1:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          accept, accept_wr, accept_rd;
    logic          push, pop, issue;
    logic [CW:0]   credit_used;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign accept_wr = accept && cmd_we;
    assign accept_rd = accept && !cmd_we;

    assign rsp_valid = (count_q != '0) && !reset;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = rd_pending_q && !reset;
    assign rsp_rdata = fifo_q[rd_ptr_q];

    // Slots spoken for: queued entries plus the beat still coming back from
    // memory, minus the entry leaving this cycle. count_q >= 1 whenever pop
    // is high, so this cannot underflow.
    assign credit_used = {1'b0, count_q} + (CW+1)'(rd_pending_q) - (CW+1)'(pop);
    assign issue       = (state_q == RD_BURST) && !reset
                         && (credit_used < (CW+1)'(RSP_DEPTH));

    assign mem_ena   = accept_wr || issue;
    assign mem_wea   = accept_wr;
    assign mem_rea   = issue;
    assign mem_addra = (state_q == RD_BURST) ? cur_addr_q : cmd_addr;
    assign mem_dia   = cmd_wdata;

    assign busy      = !reset && ((state_q != IDLE) || rd_pending_q || (count_q != '0));
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (accept_rd) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = RD_BURST;
                end
            end
            RD_BURST: begin
                if (issue) begin
                    // Address wraps naturally at 2**AW.
                    cur_addr_d = cur_addr_q + AW'(1);
                    if (remaining_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            // The memory returns data one cycle after the issue; this flag
            // marks that cycle so mem_doa gets captured.
            rd_pending_q <= issue;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage needs no reset; the count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_doa;
        end
    end

endmodule

// File: tb/tb_dram_port_ctrl.sv
module tb_dram_port_ctrl;
  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int MSIZE = 1 << AW;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          mem_ena;
  logic          mem_rea;
  logic          mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dia;
  logic [DW-1:0] mem_doa;
  logic          dbg_state;

  dram_port_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_ena(mem_ena), .mem_rea(mem_rea), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dia(mem_dia), .mem_doa(mem_doa),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory fixture (synchronous read) ----------------
  logic [DW-1:0] mem_arr [MSIZE];
  logic [31:0]   salt;
  logic          fill_mem;

  function automatic logic [DW-1:0] init_val(input int a);
    return {salt ^ (a * 32'h9E37_79B9), ~salt + 32'(a)};
  endfunction

  always @(posedge clk) begin
    if (fill_mem) begin
      for (int a = 0; a < MSIZE; a++) mem_arr[a] <= init_val(a);
    end else if (mem_ena) begin
      if (mem_wea) mem_arr[mem_addra] <= mem_dia;
      if (mem_rea) mem_doa <= mem_arr[mem_addra];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [MSIZE];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] issue_addr_q[$];
  int            issue_cyc_q[$];

  int            n_chk;
  int            n_err;
  int            cyc_n;
  int            n_issue;
  int            n_pop;
  int            last_issue_cyc;
  int            last_rise_cyc;
  int            ready_rise_cyc;
  logic          prev_hold;
  logic          prev_valid;
  logic          prev_ready;
  logic [DW-1:0] prev_data;
  logic          rand_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs were set at the falling edge, outputs are
  // sampled 1 ns later, then we move to the next falling edge.
  task automatic cyc();
    logic [AW-1:0] a;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    #1;
    if (!reset) begin
      chk("rea_wea_excl", 64'(mem_rea & mem_wea), 0);
      if (cmd_valid && cmd_ready) begin
        if (cmd_we) begin
          chk("wr_enables", {61'd0, mem_ena, mem_wea, mem_rea}, 64'b110);
          chk("wr_addr", 64'(mem_addra), 64'(cmd_addr));
          chk("wr_data", mem_dia, cmd_wdata);
          ref_mem[cmd_addr] = cmd_wdata;
        end else begin
          chk("rd_accept_no_access", 64'(mem_ena), 0);
          for (int i = 0; i <= int'(cmd_len); i++) begin
            a = AW'(int'(cmd_addr) + i);
            exp_addr_q.push_back(a);
            exp_q.push_back(ref_mem[a]);
          end
        end
      end
      if (prev_hold) begin
        chk("hold_valid", 64'(rsp_valid), 1);
        chk("hold_data", rsp_rdata, prev_data);
      end
      if (rsp_valid && !prev_valid) last_rise_cyc = cyc_n;
      if (cmd_ready && !prev_ready) ready_rise_cyc = cyc_n;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("rsp_data", rsp_rdata, exp_q.pop_front());
        n_pop++;
      end
      if (mem_ena && mem_rea) begin
        chk("issue_expected", 64'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) chk("issue_addr", 64'(mem_addra), 64'(exp_addr_q.pop_front()));
        issue_addr_q.push_back(mem_addra);
        issue_cyc_q.push_back(cyc_n);
        n_issue++;
        last_issue_cyc = cyc_n;
      end
      chk("fifo_bound", 64'((n_issue - n_pop) <= DEPTH), 1);
      prev_hold  = rsp_valid && !rsp_ready;
      prev_valid = rsp_valid;
      prev_ready = cmd_ready;
      prev_data  = rsp_rdata;
    end else begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [DW-1:0] data);
    logic acc;
    acc       = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_wdata = data;
    for (int k = 0; k < 100; k++) begin
      acc = cmd_ready;
      cyc();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(acc), 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (cmd_ready && !busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      cyc();
    end
    chk("idle_reached", 64'(done), 1);
  endtask

  task automatic clear_trace();
    issue_addr_q.delete();
    issue_cyc_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  logic [AW-1:0] seq_exp [4];
  logic [AW-1:0] ra;
  logic [DW-1:0] wd;
  int            pop_base;

  initial begin
    salt      = $urandom;
    fill_mem  = 1'b1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    rand_rdy  = 1'b0;
    n_chk = 0; n_err = 0; cyc_n = 0; n_issue = 0; n_pop = 0;
    last_issue_cyc = 0; last_rise_cyc = 0; ready_rise_cyc = 0;
    prev_hold = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    for (int a = 0; a < MSIZE; a++) ref_mem[a] = init_val(a);

    // Reset values
    repeat (3) @(negedge clk);
    fill_mem = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mem_en", {61'd0, mem_ena, mem_rea, mem_wea}, 0);
    chk("rst_state", 64'(dbg_state), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 1);
    @(negedge clk);

    // Write then read-after-write, latency 2
    rsp_ready = 1'b1;
    send_cmd(1'b1, 11'd3, 4'd0, 64'hA5A5);
    send_cmd(1'b0, 11'd3, 4'd0, '0);
    pop_base = n_pop;
    wait_idle(50);
    chk("raw_pops", 64'(n_pop - pop_base), 1);
    chk("rd_latency", 64'(last_rise_cyc - last_issue_cyc), 2);

    // Wrapping burst, back-to-back issues
    clear_trace();
    pop_base = n_pop;
    send_cmd(1'b0, 11'd2046, 4'd3, '0);
    wait_idle(50);
    seq_exp[0] = 11'd2046; seq_exp[1] = 11'd2047; seq_exp[2] = 11'd0; seq_exp[3] = 11'd1;
    chk("wrap_issue_cnt", 64'(issue_addr_q.size()), 4);
    if (issue_addr_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("wrap_addr_seq", 64'(issue_addr_q[i]), 64'(seq_exp[i]));
      chk("wrap_consecutive", 64'(issue_cyc_q[3] - issue_cyc_q[0]), 3);
      chk("ready_after_last", 64'(ready_rise_cyc), 64'(issue_cyc_q[3] + 1));
    end
    chk("wrap_pops", 64'(n_pop - pop_base), 4);

    // Stall with rsp_ready low, then drain
    rsp_ready = 1'b0;
    clear_trace();
    pop_base = n_pop;
    ra = AW'($urandom_range(0, MSIZE - 1));
    send_cmd(1'b0, ra, 4'd7, '0);
    repeat (12) cyc();
    chk("stall_issues", 64'(issue_addr_q.size()), DEPTH);
    chk("stall_valid", 64'(rsp_valid), 1);
    rsp_ready = 1'b1;
    wait_idle(100);
    chk("stall_drain_pops", 64'(n_pop - pop_base), 8);

    // Random back-pressure over a full 16-beat burst
    clear_trace();
    pop_base = n_pop;
    rand_rdy = 1'b1;
    send_cmd(1'b0, AW'($urandom_range(0, MSIZE - 1)), 4'd15, '0);
    wait_idle(400);
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(50);
    chk("rand_issues", 64'(issue_addr_q.size()), 16);
    chk("rand_pops", 64'(n_pop - pop_base), 16);

    // Reset in the middle of a burst
    clear_trace();
    rsp_ready = 1'b1;
    ra = AW'($urandom_range(0, MSIZE - 1));
    send_cmd(1'b0, ra, 4'd7, '0);
    for (int k = 0; k < 30; k++) begin
      if (issue_addr_q.size() >= 2) break;
      cyc();
    end
    chk("mid_burst_reached", 64'(issue_addr_q.size()), 2);
    reset = 1'b1;
    #1;
    chk("midrst_cmd_ready", 64'(cmd_ready), 0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_mem_en", {61'd0, mem_ena, mem_rea, mem_wea}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    n_pop = n_issue;
    #1;
    chk("midrst_ready_back", 64'(cmd_ready), 1);
    chk("midrst_state", 64'(dbg_state), 0);
    chk("midrst_busy_after", 64'(busy), 0);
    for (int k = 0; k < 8; k++) begin
      chk("no_rsp_after_rst", 64'(rsp_valid), 0);
      cyc();
    end
    pop_base = n_pop;
    send_cmd(1'b0, ra, 4'd2, '0);
    wait_idle(50);
    chk("post_rst_pops", 64'(n_pop - pop_base), 3);

    // Write while two responses are queued
    clear_trace();
    rsp_ready = 1'b0;
    pop_base  = n_pop;
    ra = AW'($urandom_range(0, MSIZE - 1));
    send_cmd(1'b0, ra, 4'd1, '0);
    repeat (5) cyc();
    chk("queued_issues", 64'(issue_addr_q.size()), 2);
    chk("queued_ready", 64'(cmd_ready), 1);
    wd = {$urandom, $urandom};
    send_cmd(1'b1, ra, 4'd0, wd);
    chk("queued_busy", 64'(busy), 1);
    rsp_ready = 1'b1;
    wait_idle(50);
    chk("queued_pops", 64'(n_pop - pop_base), 2);
    pop_base = n_pop;
    send_cmd(1'b0, ra, 4'd0, '0);
    wait_idle(50);
    chk("new_data_pops", 64'(n_pop - pop_base), 1);

    // Random command mix with random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) ra = AW'($urandom_range(0, 15));
      else ra = AW'(MSIZE - 8 + $urandom_range(0, 7));
      send_cmd(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), {$urandom, $urandom});
    end
    wait_idle(600);
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(50);
    chk("final_drained", 64'(exp_q.size()), 0);
    chk("final_issued_all", 64'(exp_addr_q.size()), 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
